// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result/immediate encodings and
// the ID/EX control bundle.
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ADD    = 4'd0,
      SUB    = 4'd1,
      SLL    = 4'd2,
      SLT    = 4'd3,
      SLTU   = 4'd4,
      XOR    = 4'd5,
      SRL    = 4'd6,
      SRA    = 4'd7,
      OR     = 4'd8,
      AND    = 4'd9,
      PASS_B = 4'd10
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      ResAlu = 2'b00,
      ResMem = 2'b01,
      ResPc4 = 2'b10
   } result_src_t;

   typedef enum logic [2:0] {
      ImmI,
      ImmS,
      ImmB,
      ImmU,
      ImmJ
   } imm_type_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        mem_read;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        alu_a_src;
      logic        alu_b_src;
      result_src_t result_src;
      alu_ctrl_t   alu_ctrl;
      logic        illegal;
   } id_ex_ctrl_t;

   // alt selects SUB/SRA; callers mask it for opcodes where bit 30 is immediate data.
   function automatic alu_ctrl_t alu_op(input logic [2:0] funct3, input logic alt);
      alu_ctrl_t op;
      unique case (funct3)
         3'b000:  op = alt ? SUB : ADD;
         3'b001:  op = SLL;
         3'b010:  op = SLT;
         3'b011:  op = SLTU;
         3'b100:  op = XOR;
         3'b101:  op = alt ? SRA : SRL;
         3'b110:  op = OR;
         default: op = AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports, one write port,
// hardwired-zero x0 and write-to-read bypass.
module register_file
   import rv32i_pkg::*;
#(
   parameter  int unsigned DATA_W    = 32,
   parameter  int unsigned REG_COUNT = 32,
   localparam int unsigned IDX_W     = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rs1,
   input  logic [IDX_W-1:0]  rs2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs_q [REG_COUNT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(REG_COUNT); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Writeback lands at the same edge ID/EX samples, so forward it here.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1 != '0) begin
         rd1 = (wr_en && (wr_addr == rs1)) ? wr_data : regs_q[rs1];
      end
      if (rs2 != '0) begin
         rd2 = (wr_en && (wr_addr == rs2)) ? wr_data : regs_q[rs2];
      end
   end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate generation, register read and
// the ID/EX pipeline register with stall/flush.
module decode_cycle
   import rv32i_pkg::*;
#(
   parameter  int unsigned INSTR_SIZE = 32,
   parameter  int unsigned REG_COUNT  = 32,
   localparam int unsigned IDX_W      = $clog2(REG_COUNT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INSTR_SIZE-1:0] instr,
   input  logic [INSTR_SIZE-1:0] pc,
   input  logic [INSTR_SIZE-1:0] pc_4,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  wb_reg_write,
   input  logic [IDX_W-1:0]      wb_rd,
   input  logic [INSTR_SIZE-1:0] wb_data,
   output logic [INSTR_SIZE-1:0] rd1_e,
   output logic [INSTR_SIZE-1:0] rd2_e,
   output logic [INSTR_SIZE-1:0] imm_e,
   output logic [IDX_W-1:0]      rs1_e,
   output logic [IDX_W-1:0]      rs2_e,
   output logic [IDX_W-1:0]      rd_e,
   output logic [INSTR_SIZE-1:0] pc_e,
   output logic [INSTR_SIZE-1:0] pc_4_e,
   output logic                  reg_write_e,
   output logic                  mem_write_e,
   output logic                  mem_read_e,
   output logic                  branch_e,
   output logic                  jump_e,
   output logic                  jalr_e,
   output logic                  alu_a_src_e,
   output logic                  alu_b_src_e,
   output logic [1:0]            result_src_e,
   output logic [3:0]            alu_ctrl_e,
   output logic [2:0]            funct3_e,
   output logic                  illegal_e
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic                  alt;
   logic [IDX_W-1:0]      rs1_a;
   logic [IDX_W-1:0]      rs2_a;
   logic [INSTR_SIZE-1:0] rd1_d;
   logic [INSTR_SIZE-1:0] rd2_d;
   logic [INSTR_SIZE-1:0] imm_d;
   logic [IDX_W-1:0]      rd_d;
   id_ex_ctrl_t           ctrl_d;
   imm_type_t             imm_type;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign alt    = instr[30];
   assign rs1_a  = instr[19:15];
   assign rs2_a  = instr[24:20];

   register_file #(
      .DATA_W   (INSTR_SIZE),
      .REG_COUNT(REG_COUNT)
   ) u_register_file (
      .clk    (clk),
      .rst    (rst),
      .rs1    (rs1_a),
      .rs2    (rs2_a),
      .rd1    (rd1_d),
      .rd2    (rd2_d),
      .wr_en  (wb_reg_write),
      .wr_addr(wb_rd),
      .wr_data(wb_data)
   );

   always_comb begin
      ctrl_d   = '0;
      imm_type = ImmI;
      case (opcode)
         OP_R: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = alu_op(funct3, alt);
         end
         OP_IMM: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_b_src = 1'b1;
            // Bit 30 is immediate data except for the shift-right pair.
            ctrl_d.alu_ctrl  = alu_op(funct3, alt && (funct3 == 3'b101));
         end
         OP_LOAD: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_read   = 1'b1;
            ctrl_d.alu_b_src  = 1'b1;
            ctrl_d.alu_ctrl   = ADD;
            ctrl_d.result_src = ResMem;
         end
         OP_STORE: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_b_src = 1'b1;
            ctrl_d.alu_ctrl  = ADD;
            imm_type         = ImmS;
         end
         OP_BRANCH: begin
            ctrl_d.branch   = 1'b1;
            ctrl_d.alu_ctrl = SUB;
            imm_type        = ImmB;
         end
         OP_JAL: begin
            ctrl_d.jump       = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.result_src = ResPc4;
            imm_type          = ImmJ;
         end
         OP_JALR: begin
            ctrl_d.jalr       = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.alu_b_src  = 1'b1;
            ctrl_d.alu_ctrl   = ADD;
            ctrl_d.result_src = ResPc4;
         end
         OP_LUI: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_b_src = 1'b1;
            ctrl_d.alu_ctrl  = PASS_B;
            imm_type         = ImmU;
         end
         OP_AUIPC: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_a_src = 1'b1;
            ctrl_d.alu_b_src = 1'b1;
            ctrl_d.alu_ctrl  = ADD;
            imm_type         = ImmU;
         end
         default: begin
            // All-zero word is the fetch reset value and passes as a silent NOP.
            ctrl_d.illegal = (instr != '0);
         end
      endcase
   end

   always_comb begin
      imm_d = '0;
      unique case (imm_type)
         ImmI: imm_d = {{(INSTR_SIZE-12){instr[31]}}, instr[31:20]};
         ImmS: imm_d = {{(INSTR_SIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
         ImmB: imm_d = {{(INSTR_SIZE-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
         ImmU: imm_d = {instr[31:12], 12'b0};
         ImmJ: imm_d = {{(INSTR_SIZE-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
         default: imm_d = '0;
      endcase
   end

   // Non-writing instructions must never look like a hazard producer.
   assign rd_d = ctrl_d.reg_write ? instr[11:7] : '0;

   id_ex_ctrl_t           ctrl_q;
   logic [INSTR_SIZE-1:0] rd1_q, rd2_q, imm_q, pc_q, pc_4_q;
   logic [IDX_W-1:0]      rs1_q, rs2_q, rd_q;
   logic [2:0]            funct3_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q   <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         imm_q    <= '0;
         pc_q     <= '0;
         pc_4_q   <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         funct3_q <= '0;
      end else if (flush) begin
         ctrl_q   <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         imm_q    <= '0;
         pc_q     <= '0;
         pc_4_q   <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         funct3_q <= '0;
      end else if (!stall) begin
         ctrl_q   <= ctrl_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         imm_q    <= imm_d;
         pc_q     <= pc;
         pc_4_q   <= pc_4;
         rs1_q    <= rs1_a;
         rs2_q    <= rs2_a;
         rd_q     <= rd_d;
         funct3_q <= funct3;
      end
   end

   assign rd1_e        = rd1_q;
   assign rd2_e        = rd2_q;
   assign imm_e        = imm_q;
   assign pc_e         = pc_q;
   assign pc_4_e       = pc_4_q;
   assign rs1_e        = rs1_q;
   assign rs2_e        = rs2_q;
   assign rd_e         = rd_q;
   assign funct3_e     = funct3_q;
   assign reg_write_e  = ctrl_q.reg_write;
   assign mem_write_e  = ctrl_q.mem_write;
   assign mem_read_e   = ctrl_q.mem_read;
   assign branch_e     = ctrl_q.branch;
   assign jump_e       = ctrl_q.jump;
   assign jalr_e       = ctrl_q.jalr;
   assign alu_a_src_e  = ctrl_q.alu_a_src;
   assign alu_b_src_e  = ctrl_q.alu_b_src;
   assign result_src_e = ctrl_q.result_src;
   assign alu_ctrl_e   = ctrl_q.alu_ctrl;
   assign illegal_e    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: instruction-level reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr, pc, pc_4, wb_data;
   logic        stall, flush, wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_4_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic        reg_write_e, mem_write_e, mem_read_e, branch_e, jump_e, jalr_e;
   logic        alu_a_src_e, alu_b_src_e, illegal_e;
   logic [1:0]  result_src_e;
   logic [3:0]  alu_ctrl_e;
   logic [2:0]  funct3_e;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decode_cycle dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .pc          (pc),
      .pc_4        (pc_4),
      .stall       (stall),
      .flush       (flush),
      .wb_reg_write(wb_reg_write),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .rd1_e       (rd1_e),
      .rd2_e       (rd2_e),
      .imm_e       (imm_e),
      .rs1_e       (rs1_e),
      .rs2_e       (rs2_e),
      .rd_e        (rd_e),
      .pc_e        (pc_e),
      .pc_4_e      (pc_4_e),
      .reg_write_e (reg_write_e),
      .mem_write_e (mem_write_e),
      .mem_read_e  (mem_read_e),
      .branch_e    (branch_e),
      .jump_e      (jump_e),
      .jalr_e      (jalr_e),
      .alu_a_src_e (alu_a_src_e),
      .alu_b_src_e (alu_b_src_e),
      .result_src_e(result_src_e),
      .alu_ctrl_e  (alu_ctrl_e),
      .funct3_e    (funct3_e),
      .illegal_e   (illegal_e)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mw, mr, br, jp, jr, asrc, bsrc;
      logic [1:0]  res;
      logic [3:0]  alu;
      logic [2:0]  f3;
      logic        ill;
   } exp_t;

   logic [31:0] m_regs [32];
   exp_t        m_exp;

   function automatic logic [31:0] rf_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_reg_write && wb_rd == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic exp_t predict(input logic [31:0] i, input logic [31:0] p,
                                    input logic [31:0] p4);
      exp_t               e;
      int                 base [8];
      logic [31:0]        ii, si, bi, ui, ji;
      logic signed [12:0] b13;
      logic signed [20:0] j21;
      logic               alt;
      base = '{0, 2, 3, 4, 5, 6, 8, 9};
      ii   = $signed(i) >>> 20;
      si   = (ii & 32'hFFFF_FFE0) | {27'd0, i[11:7]};
      b13  = {i[31], i[7], i[30:25], i[11:8], 1'b0};
      bi   = {{19{b13[12]}}, b13};
      ui   = i & 32'hFFFF_F000;
      j21  = {i[31], i[19:12], i[20], i[30:21], 1'b0};
      ji   = {{11{j21[20]}}, j21};
      e     = '0;
      e.pc  = p;
      e.pc4 = p4;
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.f3  = i[14:12];
      e.rd1 = rf_read(i[19:15]);
      e.rd2 = rf_read(i[24:20]);
      e.imm = ii;
      case (i[6:0])
         7'b0110011, 7'b0010011: begin
            alt    = i[30] && (i[6:0] == 7'b0110011 || i[14:12] == 3'd5);
            e.rw   = 1'b1;
            e.bsrc = (i[6:0] == 7'b0010011);
            e.alu  = 4'(base[i[14:12]] + ((alt && (i[14:12] == 3'd0 || i[14:12] == 3'd5)) ? 1 : 0));
         end
         7'b0000011: begin e.rw = 1; e.mr = 1; e.bsrc = 1; e.res = 2'b01; end
         7'b0100011: begin e.mw = 1; e.bsrc = 1; e.imm = si; end
         7'b1100011: begin e.br = 1; e.alu = 4'd1; e.imm = bi; end
         7'b1101111: begin e.jp = 1; e.rw = 1; e.res = 2'b10; e.imm = ji; end
         7'b1100111: begin e.jr = 1; e.rw = 1; e.bsrc = 1; e.res = 2'b10; end
         7'b0110111: begin e.rw = 1; e.bsrc = 1; e.alu = 4'd10; e.imm = ui; end
         7'b0010111: begin e.rw = 1; e.asrc = 1; e.bsrc = 1; e.imm = ui; end
         default:    e.ill = (i != 32'd0);
      endcase
      e.rd = e.rw ? i[11:7] : 5'd0;
      return e;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 32; k++) m_regs[k] <= 32'd0;
         m_exp <= '0;
      end else begin
         if (flush)       m_exp <= '0;
         else if (!stall) m_exp <= predict(instr, pc, pc_4);
         if (wb_reg_write && wb_rd != 5'd0) m_regs[wb_rd] <= wb_data;
      end
   end

   always @(negedge clk) begin
      chk("rd1_e", rd1_e, m_exp.rd1);
      chk("rd2_e", rd2_e, m_exp.rd2);
      chk("imm_e", imm_e, m_exp.imm);
      chk("pc_e", pc_e, m_exp.pc);
      chk("pc_4_e", pc_4_e, m_exp.pc4);
      chk("rs1_e", 32'(rs1_e), 32'(m_exp.rs1));
      chk("rs2_e", 32'(rs2_e), 32'(m_exp.rs2));
      chk("rd_e", 32'(rd_e), 32'(m_exp.rd));
      chk("ctrl_bits", {24'd0, reg_write_e, mem_write_e, mem_read_e, branch_e, jump_e, jalr_e,
                        alu_a_src_e, alu_b_src_e},
          {24'd0, m_exp.rw, m_exp.mw, m_exp.mr, m_exp.br, m_exp.jp, m_exp.jr, m_exp.asrc,
           m_exp.bsrc});
      chk("result_src_e", 32'(result_src_e), 32'(m_exp.res));
      chk("alu_ctrl_e", 32'(alu_ctrl_e), 32'(m_exp.alu));
      chk("funct3_e", 32'(funct3_e), 32'(m_exp.f3));
      chk("illegal_e", 32'(illegal_e), 32'(m_exp.ill));
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic [31:0] i, input logic [31:0] p);
      instr = i;
      pc    = p;
      pc_4  = p + 32'd4;
      @(negedge clk);
   endtask

   logic [31:0] vec [10];

   initial begin
      rst = 1'b0; instr = '0; pc = '0; pc_4 = '0; stall = 0; flush = 0;
      wb_reg_write = 0; wb_rd = '0; wb_data = '0;
      repeat (2) @(negedge clk);
      chk("reset_reg_write", 32'(reg_write_e), 32'd0);
      chk("reset_pc_4_e", pc_4_e, 32'd0);

      // write x5 then addi x6,x5,5
      rst = 1'b1;
      wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      drive(32'h0, 32'h0);
      wb_reg_write = 0;
      drive(32'h00528313, 32'h40);
      chk("addi_rd1", rd1_e, 32'hDEADBEEF);
      chk("addi_imm", imm_e, 32'd5);
      chk("addi_rd", 32'(rd_e), 32'd6);
      chk("addi_alu", 32'(alu_ctrl_e), 32'd0);
      chk("addi_bsrc", 32'(alu_b_src_e), 32'd1);
      chk("addi_rw", 32'(reg_write_e), 32'd1);

      // add x1,x7,x0 with x7 written the same cycle
      wb_reg_write = 1; wb_rd = 5'd7; wb_data = 32'h12345678;
      drive(32'h000380B3, 32'h44);
      chk("bypass_rd1", rd1_e, 32'h12345678);
      wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
      drive(32'h000380B3, 32'h48);
      chk("x0_rd2", rd2_e, 32'd0);
      chk("x7_stored", rd1_e, 32'h12345678);
      wb_reg_write = 0;

      drive(32'hFE208CE3, 32'h4C);  // beq x1,x2,-8
      chk("beq_imm", imm_e, 32'hFFFFFFF8);
      chk("beq_branch", 32'(branch_e), 32'd1);
      chk("beq_rd", 32'(rd_e), 32'd0);

      drive(32'h001000EF, 32'h100);  // jal x1,+2048
      chk("jal_imm", imm_e, 32'h00000800);
      chk("jal_res", 32'(result_src_e), 32'd2);
      chk("jal_pc4", pc_4_e, 32'h104);

      drive(32'hABCDE1B7, 32'h104);  // lui x3,0xABCDE
      chk("lui_imm", imm_e, 32'hABCDE000);
      chk("lui_alu", 32'(alu_ctrl_e), 32'd10);

      stall = 1;
      drive(32'h00528313, 32'h200);
      drive(32'hFFFFFFFF, 32'h204);
      drive(32'h000380B3, 32'h208);
      chk("stall_imm", imm_e, 32'hABCDE000);
      chk("stall_rd", 32'(rd_e), 32'd3);
      chk("stall_pc", pc_e, 32'h104);
      flush = 1;
      drive(32'h00528313, 32'h20C);
      chk("flush_rw", 32'(reg_write_e), 32'd0);
      chk("flush_rd", 32'(rd_e), 32'd0);
      chk("flush_rd1", rd1_e, 32'd0);
      stall = 0; flush = 0;

      drive(32'hFFFFFFFF, 32'h300);
      chk("illegal_set", 32'(illegal_e), 32'd1);
      chk("illegal_rw", 32'(reg_write_e), 32'd0);
      drive(32'h0, 32'h304);
      chk("nop_illegal", 32'(illegal_e), 32'd0);

      // srai, addi with bit30 set, sw, lw, jalr, auipc, sub, slli, sltiu, or
      vec = '{32'h4032D213, 32'h40028213, 32'h0062A623, 32'hFFC2A403, 32'h000280E7,
              32'h00001497, 32'h40628533, 32'h00329213, 32'h0FF2B213, 32'h0062E533};
      for (int k = 0; k < 10; k++) begin
         drive(vec[k], 32'h400 + 32'(4 * k));
         if (k == 0) chk("srai_alu", 32'(alu_ctrl_e), 32'd7);
         if (k == 1) chk("addi_bit30_alu", 32'(alu_ctrl_e), 32'd0);
         if (k == 2) chk("sw_imm", imm_e, 32'd12);
         if (k == 3) chk("lw_imm", imm_e, 32'hFFFFFFFC);
         if (k == 6) chk("sub_alu", 32'(alu_ctrl_e), 32'd1);
      end

      // fill x1..x31 so the reset clear is observable
      for (int k = 1; k < 32; k++) begin
         wb_reg_write = 1; wb_rd = 5'(k); wb_data = 32'h01010101 * 32'(k);
         drive(32'h00000013, 32'h500);
      end
      wb_reg_write = 0;
      drive(32'h00528313, 32'h600);
      chk("x5_filled", rd1_e, 32'h05050505);

      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rw", 32'(reg_write_e), 32'd0);
      chk("async_rd1", rd1_e, 32'd0);
      chk("async_pc", pc_e, 32'd0);
      chk("async_rd", 32'(rd_e), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k < 32; k++) begin
         drive((32'(k) << 20) | (32'(k) << 15) | 32'h33, 32'h700);
         chk("rf_cleared_rs1", rd1_e, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
